// File: rtl/lint_2_apb4_mux.sv
// LINT target port to N_SLAVES APB4 peripherals: address decode, SETUP/ACCESS phasing,
// PSTRB generation and a PREADY watchdog; decode misses and timeouts answer with an error.
`timescale 1ns/1ps

module lint_2_apb4_mux #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BE_WIDTH       = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH       = 10,
  parameter int unsigned AUX_WIDTH      = 8,
  parameter int unsigned N_SLAVES       = 4,
  parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLV_BASE = '0,
  parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLV_MASK = '0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           data_req_i,
  input  logic [ADDR_WIDTH-1:0]          data_add_i,
  input  logic                           data_wen_i,
  input  logic [DATA_WIDTH-1:0]          data_wdata_i,
  input  logic [BE_WIDTH-1:0]            data_be_i,
  input  logic [AUX_WIDTH-1:0]           data_aux_i,
  input  logic [ID_WIDTH-1:0]            data_ID_i,
  output logic                           data_gnt_o,
  output logic                           data_r_valid_o,
  output logic [DATA_WIDTH-1:0]          data_r_rdata_o,
  output logic                           data_r_opc_o,
  output logic [AUX_WIDTH-1:0]           data_r_aux_o,
  output logic [ID_WIDTH-1:0]            data_r_ID_o,
  output logic [ADDR_WIDTH-1:0]          apb_paddr_o,
  output logic [DATA_WIDTH-1:0]          apb_pwdata_o,
  output logic                           apb_pwrite_o,
  output logic [BE_WIDTH-1:0]            apb_pstrb_o,
  output logic [2:0]                     apb_pprot_o,
  output logic [N_SLAVES-1:0]            apb_psel_o,
  output logic                           apb_penable_o,
  input  logic [N_SLAVES*DATA_WIDTH-1:0] apb_prdata_i,
  input  logic [N_SLAVES-1:0]            apb_pready_i,
  input  logic [N_SLAVES-1:0]            apb_pslverr_i
);

  // A zero timeout still needs a legal one-bit counter.
  localparam int unsigned    CNT_W    = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr,  w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
  logic [BE_WIDTH-1:0]   r_strb,  w_strb_nxt;
  logic                  r_pwrite, w_pwrite_nxt;
  logic [N_SLAVES-1:0]   r_sel,   w_sel_nxt;
  logic [AUX_WIDTH-1:0]  r_aux,   w_aux_nxt;
  logic [ID_WIDTH-1:0]   r_id,    w_id_nxt;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;
  logic                  r_opc,   w_opc_nxt;
  logic [CNT_W-1:0]      r_cnt,   w_cnt_nxt;

  logic [N_SLAVES-1:0]   w_dec_sel;
  logic                  w_dec_hit;
  logic [DATA_WIDTH-1:0] w_sel_rdata;
  logic                  w_sel_ready;
  logic                  w_sel_err;
  logic                  w_timeout;

  // Address decode: first matching window in index order wins.
  always_comb begin
    w_dec_sel = '0;
    w_dec_hit = 1'b0;
    for (int i = 0; i < int'(N_SLAVES); i++) begin
      if (!w_dec_hit &&
          ((data_add_i & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
           SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        w_dec_sel[i] = 1'b1;
        w_dec_hit    = 1'b1;
      end
    end
  end

  // Only the selected slave's response is observed.
  always_comb begin
    w_sel_rdata = '0;
    for (int i = 0; i < int'(N_SLAVES); i++) begin
      if (r_sel[i]) begin
        w_sel_rdata = w_sel_rdata | apb_prdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_sel_ready = |(apb_pready_i & r_sel);
  assign w_sel_err   = |(apb_pslverr_i & r_sel);
  assign w_timeout   = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_strb_nxt   = r_strb;
    w_pwrite_nxt = r_pwrite;
    w_sel_nxt    = r_sel;
    w_aux_nxt    = r_aux;
    w_id_nxt     = r_id;
    w_rdata_nxt  = r_rdata;
    w_opc_nxt    = r_opc;
    w_cnt_nxt    = r_cnt;

    case (r_state)
      S_IDLE: begin
        if (data_req_i) begin
          w_addr_nxt   = data_add_i;
          w_wdata_nxt  = data_wdata_i;
          w_strb_nxt   = data_wen_i ? '0 : data_be_i;
          w_pwrite_nxt = ~data_wen_i;
          w_sel_nxt    = w_dec_sel;
          w_aux_nxt    = data_aux_i;
          w_id_nxt     = data_ID_i;
          if (w_dec_hit) begin
            w_state_nxt = S_SETUP;
          end else begin
            w_rdata_nxt = '0;
            w_opc_nxt   = 1'b1;
            w_state_nxt = S_RESP;
          end
        end
      end
      S_SETUP: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (w_sel_ready) begin
          w_rdata_nxt = r_pwrite ? '0 : w_sel_rdata;
          w_opc_nxt   = w_sel_err;
          w_state_nxt = S_RESP;
        end else if (w_timeout) begin
          w_rdata_nxt = '0;
          w_opc_nxt   = 1'b1;
          w_state_nxt = S_RESP;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_strb   <= '0;
      r_pwrite <= 1'b0;
      r_sel    <= '0;
      r_aux    <= '0;
      r_id     <= '0;
      r_rdata  <= '0;
      r_opc    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_strb   <= w_strb_nxt;
      r_pwrite <= w_pwrite_nxt;
      r_sel    <= w_sel_nxt;
      r_aux    <= w_aux_nxt;
      r_id     <= w_id_nxt;
      r_rdata  <= w_rdata_nxt;
      r_opc    <= w_opc_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign data_gnt_o     = (r_state == S_IDLE);
  assign data_r_valid_o = (r_state == S_RESP);
  assign data_r_rdata_o = r_rdata;
  assign data_r_opc_o   = r_opc;
  assign data_r_aux_o   = r_aux;
  assign data_r_ID_o    = r_id;

  assign apb_paddr_o    = r_addr;
  assign apb_pwdata_o   = r_wdata;
  assign apb_pwrite_o   = r_pwrite;
  assign apb_pstrb_o    = r_strb;
  assign apb_pprot_o    = 3'b000;
  assign apb_psel_o     = ((r_state == S_SETUP) || (r_state == S_ACCESS)) ? r_sel : '0;
  assign apb_penable_o  = (r_state == S_ACCESS);

endmodule

// File: tb/tb_lint_2_apb4_mux.sv
// Randomized bench for lint_2_apb4_mux: behavioural APB slaves plus a transaction-level
// reference (address map, word memories, latency formula).
`timescale 1ns/1ps

module tb_lint_2_apb4_mux;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned IW = 10;
  localparam int unsigned XW = 8;
  localparam int unsigned NS = 4;
  localparam int unsigned TO = 8;
  // Slave 3 covers a 64 KiB window overlapping slaves 0..2.
  localparam logic [NS*AW-1:0] BASES = {32'h1A10_0000, 32'h1A10_2000, 32'h1A10_1000, 32'h1A10_0000};
  localparam logic [NS*AW-1:0] MASKS = {32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000};

  logic           clk, rst;
  logic           req, wen;
  logic [AW-1:0]  add;
  logic [DW-1:0]  wdata;
  logic [BW-1:0]  be;
  logic [XW-1:0]  aux;
  logic [IW-1:0]  id;
  logic           gnt, r_valid, r_opc;
  logic [DW-1:0]  r_rdata;
  logic [XW-1:0]  r_aux;
  logic [IW-1:0]  r_id;
  logic [AW-1:0]  paddr;
  logic [DW-1:0]  pwdata;
  logic           pwrite, penable;
  logic [BW-1:0]  pstrb;
  logic [2:0]     pprot;
  logic [NS-1:0]  psel, pready, pslverr;
  logic [NS*DW-1:0] prdata;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  int          acc_cnt  [NS];
  int          wait_cfg [NS];
  logic [NS-1:0] err_cfg, noise_rdy;
  logic        mem_init;
  logic [31:0] slv_mem [NS][1024];
  logic [31:0] ref_mem [NS][1024];

  lint_2_apb4_mux #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .ID_WIDTH(IW), .AUX_WIDTH(XW),
    .N_SLAVES(NS), .SLV_BASE(BASES), .SLV_MASK(MASKS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .data_req_i(req), .data_add_i(add), .data_wen_i(wen), .data_wdata_i(wdata),
    .data_be_i(be), .data_aux_i(aux), .data_ID_i(id),
    .data_gnt_o(gnt), .data_r_valid_o(r_valid), .data_r_rdata_o(r_rdata),
    .data_r_opc_o(r_opc), .data_r_aux_o(r_aux), .data_r_ID_o(r_id),
    .apb_paddr_o(paddr), .apb_pwdata_o(pwdata), .apb_pwrite_o(pwrite),
    .apb_pstrb_o(pstrb), .apb_pprot_o(pprot), .apb_psel_o(psel),
    .apb_penable_o(penable), .apb_prdata_i(prdata), .apb_pready_i(pready),
    .apb_pslverr_i(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural APB slaves; unselected ones drive noise on PREADY and their own data.
  always_comb begin
    for (int i = 0; i < NS; i++) begin
      prdata[i*DW +: DW] = slv_mem[i][paddr[11:2]];
      pready[i]  = (psel[i] && penable) ? (acc_cnt[i] >= wait_cfg[i]) : noise_rdy[i];
      pslverr[i] = err_cfg[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      acc_cnt[i] <= (psel[i] && penable) ? acc_cnt[i] + 1 : 0;
    end
    if (mem_init) begin
      for (int i = 0; i < NS; i++)
        for (int w = 0; w < 1024; w++)
          slv_mem[i][w] <= 32'h5A00_0000 ^ (32'(i) << 16) ^ 32'(w);
    end else begin
      for (int i = 0; i < NS; i++)
        if (psel[i] && penable && pready[i] && pwrite)
          for (int b = 0; b < BW; b++)
            if (pstrb[b]) slv_mem[i][paddr[11:2]][8*b +: 8] <= pwdata[8*b +: 8];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Address map as a plain table lookup; -1 means no slave.
  function automatic int ref_slave(input logic [31:0] a);
    if (a[31:12] == 20'h1A100) return 0;
    if (a[31:12] == 20'h1A101) return 1;
    if (a[31:12] == 20'h1A102) return 2;
    if (a[31:16] == 16'h1A10)  return 3;
    return -1;
  endfunction

  task automatic run_txn(input logic [31:0] a, input logic w_en, input logic [31:0] wd,
                         input logic [3:0] b_en, input logic [9:0] t_id, input logic [7:0] t_aux,
                         input int waits);
    int s, acc, exp_lat, lat, psel_n, pen_n, setup_n, apb_bad, gnt_bad;
    logic to, exp_opc;
    logic [31:0] exp_rdata, got_rdata;
    logic [NS-1:0] exp_sel;
    logic got_opc;
    logic [9:0] got_id;
    logic [7:0] got_aux;
    s = ref_slave(a);
    exp_sel = '0;
    to = 1'b0;
    if (s >= 0) begin
      exp_sel[s]  = 1'b1;
      wait_cfg[s] = waits;
      to  = (waits >= int'(TO));
      acc = to ? int'(TO) : waits + 1;
      exp_lat   = acc + 2;
      exp_opc   = to ? 1'b1 : err_cfg[s];
      exp_rdata = (to || !w_en) ? 32'h0 : ref_mem[s][a[11:2]];
    end else begin
      acc = 0;
      exp_lat = 1;
      exp_opc = 1'b1;
      exp_rdata = 32'h0;
    end
    noise_rdy = NS'($urandom);
    @(negedge clk);
    req = 1'b1; add = a; wen = w_en; wdata = wd; be = b_en; id = t_id; aux = t_aux;
    check_eq("gnt_idle_accept", 64'(gnt), 64'd1);
    @(posedge clk);
    #1;
    req = 1'b0; add = $urandom; wdata = $urandom; be = 4'($urandom); id = 10'($urandom);
    aux = 8'($urandom); wen = 1'($urandom);
    lat = 0; psel_n = 0; pen_n = 0; setup_n = 0; apb_bad = 0; gnt_bad = 0;
    got_rdata = '0; got_opc = 1'b0; got_id = '0; got_aux = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (gnt) gnt_bad++;
      if (penable && psel == '0) apb_bad++;
      if (psel != '0) begin
        psel_n++;
        if (penable) pen_n++; else setup_n++;
        if (psel !== exp_sel || paddr !== a || pwrite !== ~w_en || pwdata !== wd ||
            pstrb !== (w_en ? 4'b0 : b_en) || pprot !== 3'b0) apb_bad++;
      end
      if (r_valid) begin
        lat = c; got_rdata = r_rdata; got_opc = r_opc; got_id = r_id; got_aux = r_aux;
        break;
      end
    end
    check_eq("latency",     64'(lat),       64'(exp_lat));
    check_eq("rdata",       64'(got_rdata), 64'(exp_rdata));
    check_eq("opc",         64'(got_opc),   64'(exp_opc));
    check_eq("id",          64'(got_id),    64'(t_id));
    check_eq("aux",         64'(got_aux),   64'(t_aux));
    check_eq("psel_cycles", 64'(psel_n),    64'(s >= 0 ? acc + 1 : 0));
    check_eq("access_cycles", 64'(pen_n),   64'(acc));
    check_eq("setup_cycles", 64'(setup_n),  64'(s >= 0 ? 1 : 0));
    check_eq("apb_signals", 64'(apb_bad),   64'd0);
    check_eq("gnt_busy",    64'(gnt_bad),   64'd0);
    @(negedge clk);
    check_eq("rvalid_pulse", 64'(r_valid),  64'd0);
    check_eq("gnt_after",    64'(gnt),      64'd1);
    if (s >= 0 && !to && !w_en)
      for (int b = 0; b < BW; b++)
        if (b_en[b]) ref_mem[s][a[11:2]][8*b +: 8] = wd[8*b +: 8];
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int rv;
    logic [31:0] a;
    int s_pick, wsel, waits;
    req = 0; add = '0; wen = 1'b1; wdata = '0; be = '0; aux = '0; id = '0;
    err_cfg = '0; noise_rdy = '0; mem_init = 1'b1; rst = 1'b1;
    for (int i = 0; i < NS; i++) begin
      wait_cfg[i] = 0;
      for (int w = 0; w < 1024; w++) ref_mem[i][w] = 32'h5A00_0000 ^ (32'(i) << 16) ^ 32'(w);
    end
    repeat (3) @(posedge clk);
    #1;
    mem_init = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_gnt",     64'(gnt),     64'd1);
    check_eq("rst_rvalid",  64'(r_valid), 64'd0);
    check_eq("rst_psel",    64'(psel),    64'd0);
    check_eq("rst_penable", 64'(penable), 64'd0);
    check_eq("rst_paddr",   64'(paddr),   64'd0);
    check_eq("rst_pstrb",   64'(pstrb),   64'd0);
    check_eq("rst_pwrite",  64'(pwrite),  64'd0);
    check_eq("rst_rdata",   64'(r_rdata), 64'd0);
    check_eq("rst_opc",     64'(r_opc),   64'd0);

    run_txn(32'h1A10_1000, 1'b0, 32'hCAFE_F00D, 4'hF,   10'h001, 8'h11, 0);
    run_txn(32'h1A10_1000, 1'b1, 32'h0,         4'hF,   10'h02A, 8'h55, 0);
    run_txn(32'h1A10_2008, 1'b0, 32'h1234_5678, 4'b0011, 10'h0B1, 8'h22, 3);
    run_txn(32'h1A10_2008, 1'b1, 32'h0,         4'hF,   10'h0B2, 8'h23, 1);
    run_txn(32'hDEAD_0000, 1'b1, 32'h0,         4'hF,   10'h3FF, 8'hEE, 0);
    run_txn(32'h1A10_2010, 1'b1, 32'h0,         4'hF,   10'h010, 8'h01, 255);
    run_txn(32'h1A10_2010, 1'b1, 32'h0,         4'hF,   10'h011, 8'h02, 0);
    run_txn(32'h1A10_2014, 1'b0, 32'hA5A5_A5A5, 4'hF,   10'h012, 8'h03, 7);
    err_cfg = 4'b1001;
    run_txn(32'h1A10_0004, 1'b1, 32'h0,         4'hF,   10'h020, 8'h30, 0);
    run_txn(32'h1A10_1004, 1'b1, 32'h0,         4'hF,   10'h021, 8'h31, 0);
    run_txn(32'h1A10_5000, 1'b1, 32'h0,         4'hF,   10'h022, 8'h32, 2);
    err_cfg = '0;

    // Reset while a stalled transfer is in ACCESS: no response may follow.
    wait_cfg[1] = 255;
    @(negedge clk);
    req = 1'b1; add = 32'h1A10_1008; wen = 1'b1; be = 4'hF; id = 10'h155; aux = 8'h77;
    @(posedge clk);
    #1;
    req = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_psel", 64'(psel), 64'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_psel",    64'(psel),    64'd0);
    check_eq("midrst_penable", 64'(penable), 64'd0);
    check_eq("midrst_gnt",     64'(gnt),     64'd1);
    check_eq("midrst_rvalid",  64'(r_valid), 64'd0);
    rv = 0;
    repeat (6) begin
      @(negedge clk);
      if (r_valid) rv++;
    end
    check_eq("midrst_no_resp", 64'(rv), 64'd0);
    run_txn(32'h1A10_1008, 1'b1, 32'h0, 4'hF, 10'h156, 8'h78, 0);

    for (int n = 0; n < 60; n++) begin
      s_pick = $urandom_range(0, 4);
      case (s_pick)
        0: a = 32'h1A10_0000 | ($urandom & 32'h0000_0FFC);
        1: a = 32'h1A10_1000 | ($urandom & 32'h0000_0FFC);
        2: a = 32'h1A10_2000 | ($urandom & 32'h0000_0FFC);
        3: a = 32'h1A10_3000 + ($urandom_range(0, 32'h0000_CFFF) & 32'hFFFF_FFFC);
        default: a = {16'hDEAD, 16'($urandom)};
      endcase
      wsel = $urandom_range(0, 9);
      waits = (wsel <= 6) ? wsel % 4 : (wsel == 7) ? 7 : 255;
      for (int i = 0; i < NS; i++) err_cfg[i] = ($urandom_range(0, 5) == 0);
      run_txn(a, 1'($urandom), $urandom, 4'($urandom), 10'($urandom), 8'($urandom), waits);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
